// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RV32I core: sequences fetch/decode/execute/
// memory/write-back, drives datapath selects and counts retired instructions.
module controle_multiciclo #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic             pc_write_q, pc_write_d;
  logic             pc_src_q, pc_src_d;
  logic [1:0]       alu_src_a_q, alu_src_a_d;
  logic [1:0]       alu_src_b_q, alu_src_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             reg_write_q, reg_write_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic             take;
  logic             fetch_done;

  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_R:              return S_EXEC_R;
      OP_I:              return S_EXEC_I;
      OP_LOAD, OP_STORE: return S_MEM_ADDR;
      OP_BR:             return S_BRANCH;
      OP_JAL:            return S_JAL;
      OP_LUI:            return S_LUI;
      default:           return S_TRAP;
    endcase
  endfunction

  // Next-state logic; reset wins over every transition, including TRAP.
  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
        S_DECODE:   state_d = decode_next(opcode);
        S_EXEC_R:   state_d = S_WB_ALU;
        S_EXEC_I:   state_d = S_WB_ALU;
        S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
        S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
        S_WB_MEM:   state_d = S_FETCH;
        S_WB_ALU:   state_d = S_FETCH;
        S_LUI:      state_d = S_WB_ALU;
        S_JAL:      state_d = S_FETCH;
        S_BRANCH:   state_d = S_FETCH;
        S_TRAP:     state_d = S_TRAP;
        default:    state_d = S_TRAP;
      endcase
    end
  end

  // Retire counter (bumps on every entry into FETCH) and sticky illegal flag.
  always_comb begin
    count_d   = count_q;
    illegal_d = illegal_q;
    if (rst) begin
      count_d   = {CNT_W{1'b0}};
      illegal_d = 1'b0;
    end else begin
      if (state_d == S_FETCH && state_q != S_FETCH) begin
        count_d = count_q + CNT_W'(1);
      end else begin
        count_d = count_q;
      end
      if (state_d == S_TRAP) begin
        illegal_d = 1'b1;
      end else begin
        illegal_d = illegal_q;
      end
    end
  end

  // Moore outputs decoded from the next state so they register alongside it.
  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    pc_write_d  = 1'b0;
    pc_src_d    = 1'b0;
    alu_src_a_d = 2'd0;
    alu_src_b_d = 2'd0;
    alu_op_d    = 2'd0;
    reg_write_d = 1'b0;
    wb_sel_d    = 2'd0;
    case (state_d)
      S_FETCH: begin
        mem_req_d   = 1'b1;
        alu_src_b_d = 2'd2;
      end
      S_DECODE:   alu_src_b_d = 2'd1;
      S_EXEC_R: begin
        alu_src_a_d = 2'd1;
        alu_op_d    = 2'd2;
      end
      S_EXEC_I: begin
        alu_src_a_d = 2'd1;
        alu_src_b_d = 2'd1;
        alu_op_d    = 2'd2;
      end
      S_MEM_ADDR: begin
        alu_src_a_d = 2'd1;
        alu_src_b_d = 2'd1;
      end
      S_MEM_RD:   mem_req_d = 1'b1;
      S_MEM_WR: begin
        mem_req_d = 1'b1;
        mem_we_d  = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_d = 1'b1;
        wb_sel_d    = 2'd1;
      end
      S_WB_ALU:   reg_write_d = 1'b1;
      S_LUI: begin
        alu_src_a_d = 2'd2;
        alu_src_b_d = 2'd1;
      end
      S_JAL: begin
        reg_write_d = 1'b1;
        wb_sel_d    = 2'd2;
        pc_write_d  = 1'b1;
        pc_src_d    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d = 2'd1;
        alu_op_d    = 2'd1;
        pc_src_d    = 1'b1;
      end
      S_TRAP:     mem_req_d = 1'b0;
      default:    mem_req_d = 1'b0;
    endcase
  end

  // Single state/output register bank.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    count_q     <= count_d;
    illegal_q   <= illegal_d;
    mem_req_q   <= mem_req_d;
    mem_we_q    <= mem_we_d;
    pc_write_q  <= pc_write_d;
    pc_src_q    <= pc_src_d;
    alu_src_a_q <= alu_src_a_d;
    alu_src_b_q <= alu_src_b_d;
    alu_op_q    <= alu_op_d;
    reg_write_q <= reg_write_d;
    wb_sel_q    <= wb_sel_d;
  end

  // Fetch completion and branch decision must act in the same cycle as their inputs.
  assign take       = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);
  assign fetch_done = (state_q == S_FETCH) & mem_ready;

  assign mem_req     = ~rst & mem_req_q;
  assign mem_we      = ~rst & mem_we_q;
  assign ir_write    = ~rst & fetch_done;
  assign pc_write    = ~rst & (fetch_done | pc_write_q | ((state_q == S_BRANCH) & take));
  assign pc_src      = ~rst & pc_src_q;
  assign alu_src_a   = {2{~rst}} & alu_src_a_q;
  assign alu_src_b   = {2{~rst}} & alu_src_b_q;
  assign alu_op      = {2{~rst}} & alu_op_q;
  assign reg_write   = ~rst & reg_write_q;
  assign wb_sel      = {2{~rst}} & wb_sel_q;
  assign illegal     = ~rst & illegal_q;
  assign instr_count = {CNT_W{~rst}} & count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: walks each instruction class through
// its state trace and checks outputs against hand-computed values.
module tb_controle_multiciclo;
  localparam int CNT_W = 4;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             zero;
  logic             mem_ready;
  logic             mem_req, mem_we, ir_write, pc_write, pc_src;
  logic [1:0]       alu_src_a, alu_src_b, alu_op, wb_sel;
  logic             reg_write, illegal;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  controle_multiciclo #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal),
    .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // FETCH with zero-wait memory, then DECODE; leaves the FSM entering the exec state.
  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
    mem_ready = 1'b1;
    #1;
    check("fetch_state", 32'(state), 32'd0);
    check("fetch_mem_req", 32'(mem_req), 32'd1);
    check("fetch_ir_write", 32'(ir_write), 32'd1);
    check("fetch_pc_write", 32'(pc_write), 32'd1);
    tick();
    mem_ready = 1'b0;
    #1;
    check("decode_state", 32'(state), 32'd1);
    check("decode_mem_req", 32'(mem_req), 32'd0);
    check("decode_src_b", 32'(alu_src_b), 32'd1);
    tick();
  endtask

  task automatic expect_retire(input string tag);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_count"}, 32'(instr_count), 32'(exp_cnt));
    check({tag, "_reg_write"}, 32'(reg_write), 32'd0);
  endtask

  task automatic run_add();
    fetch_decode(OP_R, 3'b000);
    check("add_exec_state", 32'(state), 32'd2);
    check("add_alu_op", 32'(alu_op), 32'd2);
    check("add_src_a", 32'(alu_src_a), 32'd1);
    tick();
    check("add_wb_state", 32'(state), 32'd8);
    check("add_reg_write", 32'(reg_write), 32'd1);
    check("add_wb_sel", 32'(wb_sel), 32'd0);
    check("add_wb_mem_req", 32'(mem_req), 32'd0);
    tick();
    expect_retire("add");
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_pc_write", 32'(pc_write), 32'd0);
    rst = 1'b0;
    #1;
    check("fetch_src_b", 32'(alu_src_b), 32'd2);
    check("fetch_pc_src", 32'(pc_src), 32'd0);

    run_add();

    // LW with three wait cycles in MEM_RD
    fetch_decode(OP_LD, 3'b010);
    check("lw_addr_state", 32'(state), 32'd4);
    check("lw_addr_src_b", 32'(alu_src_b), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("lw_wait_state", 32'(state), 32'd5);
      check("lw_wait_req", 32'(mem_req), 32'd1);
      check("lw_wait_we", 32'(mem_we), 32'd0);
      check("lw_wait_reg_write", 32'(reg_write), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("lw_ready_state", 32'(state), 32'd5);
    check("lw_ready_req", 32'(mem_req), 32'd1);
    tick();
    mem_ready = 1'b0;
    #1;
    check("lw_wb_state", 32'(state), 32'd7);
    check("lw_wb_reg_write", 32'(reg_write), 32'd1);
    check("lw_wb_sel", 32'(wb_sel), 32'd1);
    tick();
    expect_retire("lw");

    // BEQ then BNE; zero toggled within the BRANCH cycle
    for (int f = 0; f < 2; f++) begin
      fetch_decode(OP_BR, 3'(f));
      check("br_state", 32'(state), 32'd9);
      check("br_alu_op", 32'(alu_op), 32'd1);
      check("br_pc_src", 32'(pc_src), 32'd1);
      zero = 1'b1;
      #1;
      check("br_zero1_pc_write", 32'(pc_write), (f == 0) ? 32'd1 : 32'd0);
      zero = 1'b0;
      #1;
      check("br_zero0_pc_write", 32'(pc_write), (f == 0) ? 32'd0 : 32'd1);
      funct3 = 3'b100;
      #1;
      check("br_other_f3", 32'(pc_write), 32'd0);
      check("br_reg_write", 32'(reg_write), 32'd0);
      tick();
      expect_retire("br");
    end

    // SW, zero-wait memory
    fetch_decode(OP_ST, 3'b010);
    check("sw_addr_state", 32'(state), 32'd4);
    tick();
    mem_ready = 1'b1;
    #1;
    check("sw_state", 32'(state), 32'd6);
    check("sw_mem_we", 32'(mem_we), 32'd1);
    check("sw_mem_req", 32'(mem_req), 32'd1);
    check("sw_reg_write", 32'(reg_write), 32'd0);
    tick();
    expect_retire("sw");

    // JAL
    fetch_decode(OP_JAL, 3'b000);
    check("jal_state", 32'(state), 32'd10);
    check("jal_reg_write", 32'(reg_write), 32'd1);
    check("jal_wb_sel", 32'(wb_sel), 32'd2);
    check("jal_pc_write", 32'(pc_write), 32'd1);
    check("jal_pc_src", 32'(pc_src), 32'd1);
    tick();
    expect_retire("jal");

    // LUI -> WB_ALU
    fetch_decode(OP_LUI, 3'b000);
    check("lui_state", 32'(state), 32'd11);
    check("lui_src_a", 32'(alu_src_a), 32'd2);
    check("lui_src_b", 32'(alu_src_b), 32'd1);
    tick();
    check("lui_wb_state", 32'(state), 32'd8);
    tick();
    expect_retire("lui");

    // ADDI -> EXEC_I -> WB_ALU
    fetch_decode(OP_I, 3'b000);
    check("addi_state", 32'(state), 32'd3);
    check("addi_src_b", 32'(alu_src_b), 32'd1);
    check("addi_alu_op", 32'(alu_op), 32'd2);
    tick();
    check("addi_wb_reg_write", 32'(reg_write), 32'd1);
    tick();
    expect_retire("addi");
    check("count_after_8", 32'(instr_count), 32'd8);

    // Reset during MEM_WR wait aborts with no partial writes
    fetch_decode(OP_ST, 3'b010);
    tick();
    check("swwait_state", 32'(state), 32'd6);
    check("swwait_count", 32'(instr_count), 32'd8);
    rst = 1'b1;
    #1;
    check("swrst_mem_req", 32'(mem_req), 32'd0);
    check("swrst_pc_write", 32'(pc_write), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("swrst_state", 32'(state), 32'd0);
    check("swrst_count", 32'(instr_count), 32'd0);
    exp_cnt = 0;

    // Unsupported opcode -> TRAP, sticky until reset
    fetch_decode(OP_SYS, 3'b000);
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("trap_state", 32'(state), 32'd15);
      check("trap_illegal", 32'(illegal), 32'd1);
      check("trap_mem_req", 32'(mem_req), 32'd0);
      tick();
    end
    mem_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("trap_rst_state", 32'(state), 32'd0);
    check("trap_rst_illegal", 32'(illegal), 32'd0);
    check("trap_rst_count", 32'(instr_count), 32'd0);

    // Counter wrap at 2^CNT_W
    for (int i = 0; i < (1 << CNT_W) - 1; i++) run_add();
    check("count_max", 32'(instr_count), 32'((1 << CNT_W) - 1));
    run_add();
    check("count_wrap", 32'(instr_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
